pipe_stage_skid: RTL and testbench

- Generic, parametrised pipeline-stage register that replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload plus PC and a branch-prediction bit under a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready, so backpressure does not form a combinational path across stages.
- A flush input discards both entries and zeroes them, for branch-mispredict recovery.

---
 rtl/pipe_stage_skid_pkg.sv | 20 ++
 rtl/pipe_entry_reg.sv | 31 +++
 rtl/pipe_stage_skid.sv | 147 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants for the pipeline-stage skid register: FSM state encodings,
// default widths and per-stage payload widths used by the instantiating stages.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } ps_state_e;

  localparam int DEF_DATA_W     = 128;
  localparam int DEF_PC_W       = 32;
  localparam int DEF_PERF_CNT_W = 16;

  localparam int IFID_PAYLOAD_W  = 32;
  localparam int IDEX_PAYLOAD_W  = 128;
  localparam int EXMEM_PAYLOAD_W = 80;
  localparam int MEMWB_PAYLOAD_W = 40;

endpackage

// File: rtl/pipe_entry_reg.sv
// One {data, pc, pred} entry of the skid stage; clear has priority over load.
module pipe_entry_reg
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PC_W   = DEF_PC_W
) (
  input  logic              clk,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [PC_W-1:0]   d_pc,
  input  logic              d_pred,
  output logic [DATA_W-1:0] q_data,
  output logic [PC_W-1:0]   q_pc,
  output logic              q_pred
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q_data <= '0;
      q_pc   <= '0;
      q_pred <= 1'b0;
    end else if (load) begin
      q_data <= d_data;
      q_pc   <= d_pc;
      q_pred <= d_pred;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline-stage register with a 2-entry skid buffer and registered in_ready.
// Optional stall/bubble counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PC_W        = DEF_PC_W,
  parameter int ZERO_BUBBLE = 1,
  parameter int PERF_CNT_W  = DEF_PERF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_pred,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_pred
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt,
  output logic [PERF_CNT_W-1:0] perf_bubble_cnt
`endif
);

  ps_state_e state_p1, state_nxt;
  logic      in_ready_p1;
  logic      in_fire, out_fire, kill;
  logic      main_load, main_sel_skid, main_drain, skid_load, skid_drain;
  logic      main_clear, skid_clear;

  logic [DATA_W-1:0] skid_data, main_d_data;
  logic [PC_W-1:0]   skid_pc, main_d_pc;
  logic              skid_pred, main_d_pred;

  assign in_ready  = in_ready_p1;
  assign out_valid = (state_p1 != PS_EMPTY);
  assign in_fire   = in_valid & in_ready_p1;
  assign out_fire  = out_valid & out_ready;
  assign kill      = ~rst_n | flush;

  always_comb begin
    state_nxt     = state_p1;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    main_drain    = 1'b0;
    skid_load     = 1'b0;
    skid_drain    = 1'b0;
    case (state_p1)
      PS_EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_nxt = PS_ONE;
        end
      end
      PS_ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_nxt = PS_FULL;
        end else if (out_fire) begin
          main_drain = 1'b1;
          state_nxt  = PS_EMPTY;
        end
      end
      PS_FULL: begin
        // in_ready is low here, so only the drain side can move
        if (out_fire) begin
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
          skid_drain    = 1'b1;
          state_nxt     = PS_ONE;
        end
      end
      default: state_nxt = PS_EMPTY;
    endcase
    if (flush) state_nxt = PS_EMPTY;
  end

  // Stage register: control state; in_ready is precomputed from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1    <= PS_EMPTY;
      in_ready_p1 <= 1'b1;
    end else begin
      state_p1    <= state_nxt;
      in_ready_p1 <= (state_nxt != PS_FULL);
    end
  end

  assign main_clear  = kill | ((ZERO_BUBBLE != 0) & main_drain);
  assign skid_clear  = kill | ((ZERO_BUBBLE != 0) & skid_drain);
  assign main_d_data = main_sel_skid ? skid_data : in_data;
  assign main_d_pc   = main_sel_skid ? skid_pc   : in_pc;
  assign main_d_pred = main_sel_skid ? skid_pred : in_pred;

  pipe_entry_reg #(.DATA_W(DATA_W), .PC_W(PC_W)) u_main (
    .clk    (clk),
    .load   (main_load),
    .clear  (main_clear),
    .d_data (main_d_data),
    .d_pc   (main_d_pc),
    .d_pred (main_d_pred),
    .q_data (out_data),
    .q_pc   (out_pc),
    .q_pred (out_pred)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .PC_W(PC_W)) u_skid (
    .clk    (clk),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_data (in_data),
    .d_pc   (in_pc),
    .d_pred (in_pred),
    .q_data (skid_data),
    .q_pc   (skid_pc),
    .q_pred (skid_pred)
  );

`ifdef PIPE_PERF_CNT_EN
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Counters: reset-only clear, flush leaves them alone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) perf_stall_cnt <= sat_inc(perf_stall_cnt);
      if (!out_valid) perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
    end
  end
`else
  logic unused_perf_w;
  assign unused_perf_w = (PERF_CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed table-driven bench for pipe_stage_skid, plus multi-cycle corner sequences.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int PW = 32;
  localparam int CW = 4;

  logic          clk, rst_n, flush, in_valid, out_ready, in_pred;
  logic [DW-1:0] in_data;
  logic [PW-1:0] in_pc;
  logic          in_ready, out_valid, out_pred;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_pc;
  logic          nz_in_ready, nz_out_valid, nz_out_pred;
  logic [DW-1:0] nz_out_data;
  logic [PW-1:0] nz_out_pc;
`ifdef PIPE_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, bubble_cnt, nz_stall_cnt, nz_bubble_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_skid #(.DATA_W(DW), .PC_W(PW), .ZERO_BUBBLE(1), .PERF_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc), .in_pred(in_pred),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc),
    .out_pred(out_pred)
`ifdef PIPE_PERF_CNT_EN
    , .perf_stall_cnt(stall_cnt), .perf_bubble_cnt(bubble_cnt)
`endif
  );

  pipe_stage_skid #(.DATA_W(DW), .PC_W(PW), .ZERO_BUBBLE(0), .PERF_CNT_W(CW)) dut_nz (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(nz_in_ready), .in_data(in_data), .in_pc(in_pc), .in_pred(in_pred),
    .out_valid(nz_out_valid), .out_ready(out_ready), .out_data(nz_out_data), .out_pc(nz_out_pc),
    .out_pred(nz_out_pred)
`ifdef PIPE_PERF_CNT_EN
    , .perf_stall_cnt(nz_stall_cnt), .perf_bubble_cnt(nz_bubble_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic          rst_n;
    logic          flush;
    logic          iv;
    logic          ordy;
    logic [PW-1:0] pc;
    logic          ev;
    logic [PW-1:0] epc;
    logic          eir;
  } vec_t;

  vec_t vt[22];

  function automatic logic [DW-1:0] data_of(input logic [PW-1:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [PW-1:0] pc);
    rst_n     = r;
    flush     = f;
    in_valid  = iv;
    out_ready = ordy;
    in_pc     = pc;
    in_data   = data_of(pc);
    in_pred   = pc[2];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [PW-1:0] epc,
                         input logic eir);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, " out_pc"}, out_pc, ev ? epc : '0);
    chk({tag, " out_data"}, out_data, ev ? data_of(epc) : '0);
    chk({tag, " out_pred"}, 32'(out_pred), ev ? 32'(epc[2]) : 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'(eir));
  endtask

  initial begin
    //          rst  fl  iv  ordy pc          ev  epc         eir
    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 1'b1};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 32'h00, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h04, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h08, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h10, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h14, 1'b1, 32'h10, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h18, 1'b1, 32'h10, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h14, 1'b1};
    vt[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h18, 1'b1};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 1'b1};
    vt[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h30, 1'b1, 32'h30, 1'b1};
    vt[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h34, 1'b1, 32'h30, 1'b0};
    vt[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 32'h00, 1'b1};
    vt[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 1'b1};
    vt[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 32'h40, 1'b1};
    vt[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 32'h00, 1'b1};
    vt[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 1'b1};
    vt[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h50, 1'b1, 32'h50, 1'b1};
    vt[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h54, 1'b0, 32'h00, 1'b1};
    vt[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 1'b1};

    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 22; i++) begin
      drive(vt[i].rst_n, vt[i].flush, vt[i].iv, vt[i].ordy, vt[i].pc);
      step();
      chk_out($sformatf("vec%0d", i), vt[i].ev, vt[i].epc, vt[i].eir);
    end

    // Back-to-back transfers while in ONE: every PC must appear exactly once
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
    step();
    chk_out("one_prime", 1'b1, 32'h100, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100 + 32'(4 * k));
      step();
      chk_out($sformatf("one_ff%0d", k), 1'b1, 32'h100 + 32'(4 * k), 1'b1);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
    step();
    chk_out("one_drain", 1'b0, '0, 1'b1);

    // Drained entry: zeroed with ZERO_BUBBLE=1, retained with ZERO_BUBBLE=0
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h60);
    step();
    chk("nz_load_pc", nz_out_pc, 32'h60);
    drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
    step();
    chk_out("zb1_drain", 1'b0, '0, 1'b1);
    chk("zb0_valid", 32'(nz_out_valid), 32'd0);
    chk("zb0_pc", nz_out_pc, 32'h60);
    chk("zb0_data", nz_out_data, data_of(32'h60));

`ifdef PIPE_PERF_CNT_EN
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    chk("perf_rst_stall", 32'(stall_cnt), 32'd0);
    chk("perf_rst_bubble", 32'(bubble_cnt), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h70);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 20; k++) step();
    chk("perf_stall_sat", 32'(stall_cnt), 32'd15);
    chk("perf_bubble", 32'(bubble_cnt), 32'd1);
    chk_out("perf_hold", 1'b1, 32'h70, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step();
    chk("perf_flush_stall", 32'(stall_cnt), 32'd15);
    chk("perf_flush_bubble", 32'(bubble_cnt), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    chk("perf_rst2_stall", 32'(stall_cnt), 32'd0);
    chk("perf_rst2_bubble", 32'(bubble_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
